seq_detect_param: RTL and testbench

Parametrised serial pattern detector. It watches a qualified 1-bit input stream for a runtime-loadable PAT_W-bit pattern and raises a same-cycle (Mealy) match flag. It supports overlapping and non-overlapping detection modes and keeps a saturating match counter. It is the drop-in successor for fixed-pattern serial detectors in the datapath and sits directly after the serial bit source.

---
 rtl/seq_detect_param_pkg.sv | 33 +++
 rtl/seq_detect_param_sat_counter.sv | 40 ++++
 rtl/seq_detect_param.sv | 132 +++++++++++++
 tb/tb_seq_detect_param.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_param_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_param_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - fill_state_e    : two-state encoding of the history fill level
//   - RST_PAT_DEFAULT : default pattern loaded at reset
//   - legal ranges for PAT_W / CNT_W, used by elaboration-time checks
// ---------------------------------------------------------------------------
package seq_detect_param_pkg;

    // FILL  : fewer than PAT_W-1 valid history bits, no match possible
    // ARMED : history is full, the next valid bit can complete a match
    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fill_state_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;
    localparam int CNT_W_MIN = 1;

    localparam logic [2:0] RST_PAT_DEFAULT = 3'b101;

    // True when a pattern width is within the supported range.
    function automatic bit pat_w_legal(input int w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

    // True when a counter width is within the supported range.
    function automatic bit cnt_w_legal(input int w);
        return (w >= CNT_W_MIN);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Reusable saturating up-counter.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   inc   : increment request; ignored once the counter holds all-ones
//   clr   : synchronous clear; wins over a same-cycle increment
//   count : registered count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] count_r;

    // Count register: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
// Serial pattern detector with a runtime-loadable PAT_W-bit pattern, a
// same-cycle (Mealy) match flag, overlapping / non-overlapping modes and a
// saturating match counter.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i           : serial data bit
//   in_valid    : qualifies i; when low, history and fill level are frozen
//   pat_in      : new pattern, pat_in[PAT_W-1] is the first-received bit
//   load        : latch pat_in, flush history, discard same-cycle bit
//   overlap     : 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr     : synchronous clear of match_count
//   o           : combinational match flag
//   match_count : registered saturating number of matches
//   armed       : registered, history holds PAT_W-1 valid bits
// ---------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_param_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(RST_PAT_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             load,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             o,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    // Parameter range checks at elaboration.
    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W=%0d outside %0d..%0d", PAT_W, PAT_W_MIN, PAT_W_MAX);
    end
    if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W=%0d below %0d", CNT_W, CNT_W_MIN);
    end

    // fill ranges over 0..PAT_W-1, which always fits in clog2(PAT_W) bits
    localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_r;
    logic [PAT_W-2:0]  hist_nxt_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  pat_nxt_s;
    fill_state_e       state_r;
    fill_state_e       state_nxt_s;

    logic [PAT_W-1:0]  window_s;
    logic              match_s;

    // The candidate window is the stored history with the current bit appended
    // as the newest (least significant) position.
    assign window_s = {hist_r, i};

    // Mealy match; load suppresses it because the bit is being discarded.
    assign match_s = in_valid & (state_r == ARMED) & (window_s == pat_r) & ~load;

    // State register: history, fill level, pattern and fill-state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r  <= {(PAT_W-1){1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            pat_r   <= RST_PAT;
            state_r <= FILL;
        end else begin
            hist_r  <= hist_nxt_s;
            fill_r  <= fill_nxt_s;
            pat_r   <= pat_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: load flush, qualified shift, non-overlap restart.
    always_comb begin
        hist_nxt_s  = hist_r;
        fill_nxt_s  = fill_r;
        pat_nxt_s   = pat_r;
        state_nxt_s = state_r;

        if (load) begin
            pat_nxt_s  = pat_in;
            hist_nxt_s = {(PAT_W-1){1'b0}};
            fill_nxt_s = {FILL_W{1'b0}};
        end else if (in_valid) begin
            // Dropping the oldest bit of the window keeps the newest PAT_W-1.
            hist_nxt_s = window_s[PAT_W-2:0];
            if (match_s && !overlap) begin
                // Non-overlapping: the next match needs PAT_W fresh bits.
                fill_nxt_s = {FILL_W{1'b0}};
            end else if (fill_r != FILL_MAX) begin
                fill_nxt_s = fill_r + FILL_W'(1);
            end else begin
                fill_nxt_s = fill_r;
            end
        end else begin
            // Gap in the stream: everything holds.
            hist_nxt_s = hist_r;
        end

        case (fill_nxt_s == FILL_MAX)
            1'b1:    state_nxt_s = ARMED;
            1'b0:    state_nxt_s = FILL;
            default: state_nxt_s = FILL;
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_s),
        .clr   (cnt_clr),
        .count (match_count)
    );

    assign o     = match_s;
    assign armed = (state_r == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
// Directed plus randomized stimulus for seq_detect_param (PAT_W=3, CNT_W=2).
// The stimulus process drives one cycle at a time, runs a behavioural model
// (a list of fresh stream bits and an integer count) and pushes the expected
// o / armed / match_count for that cycle into a queue. A monitor pops and
// compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int PAT_W = 3;
    localparam int CNT_W = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             i;
    logic             in_valid;
    logic [PAT_W-1:0] pat_in;
    logic             load;
    logic             overlap;
    logic             cnt_clr;
    logic             o;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    seq_detect_param #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .RST_PAT (3'b101)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i           (i),
        .in_valid    (in_valid),
        .pat_in      (pat_in),
        .load        (load),
        .overlap     (overlap),
        .cnt_clr     (cnt_clr),
        .o           (o),
        .match_count (match_count),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       o;
        logic       armed;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    int vectors;
    int miscompares;

    // Behavioural model state
    bit m_bits[$];      // fresh stream bits since reset / load / non-overlap match
    int m_pat;
    int m_cnt;

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (o !== e.o) begin
                miscompares++;
                $display("FAIL o @%0t: got %b, want %b", $time, o, e.o);
            end
            if (armed !== e.armed) begin
                miscompares++;
                $display("FAIL armed @%0t: got %b, want %b", $time, armed, e.armed);
            end
            if (match_count !== CNT_W'(e.cnt)) begin
                miscompares++;
                $display("FAIL match_count @%0t: got %0d, want %0d", $time, match_count, e.cnt);
            end
        end
    end

    // One cycle of stimulus with its model step and expectation.
    task automatic cyc(input bit rst, input bit v, input bit b, input bit ld,
                       input int pin, input bit ov, input bit clr);
        exp_t e;
        bit   is_armed;
        int   w;
        @(posedge clk);
        #1;
        rst_n    = ~rst;
        in_valid = v;
        i        = b;
        load     = ld;
        pat_in   = PAT_W'(pin);
        overlap  = ov;
        cnt_clr  = clr;
        if (rst) begin
            m_bits.delete();
            m_pat = 5;
            m_cnt = 0;
            e.o = 1'b0; e.armed = 1'b0; e.cnt = 0;
        end else begin
            is_armed = (m_bits.size() >= PAT_W - 1);
            w = 0;
            if (is_armed) begin
                for (int k = m_bits.size() - (PAT_W - 1); k < m_bits.size(); k++)
                    w = (w << 1) | int'(m_bits[k]);
                w = (w << 1) | int'(b);
            end
            e.armed = is_armed;
            e.cnt   = m_cnt;
            e.o     = v && !ld && is_armed && (w == m_pat);
            if (ld) begin
                m_pat = pin;
                m_bits.delete();
            end else if (v) begin
                if (e.o && !ov) begin
                    m_bits.delete();
                end else begin
                    m_bits.push_back(b);
                    if (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
                end
            end
            if (clr) m_cnt = 0;
            else if (e.o && m_cnt < CNT_SAT) m_cnt++;
        end
        exp_q.push_back(e);
    endtask

    task automatic bit_in(input bit b, input bit ov);
        cyc(1'b0, 1'b1, b, 1'b0, 0, ov, 1'b0);
    endtask

    task automatic gap();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic load_pat(input int p);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0);
    endtask

    task automatic clr_cnt();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    endtask

    initial begin
        bit ov_r;
        vectors = 0;
        miscompares = 0;
        m_pat = 5; m_cnt = 0;
        rst_n = 1'b0; i = 1'b0; in_valid = 1'b0; pat_in = '0;
        load = 1'b0; overlap = 1'b1; cnt_clr = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Overlapping 1,0,1,0,1 against 101
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
        clr_cnt();
        load_pat(5);

        // Non-overlapping, same stream, then the armed gap afterwards
        bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
        gap(); gap();
        load_pat(5);

        // Gaps between every bit
        bit_in(1, 1); gap(); bit_in(0, 1); gap(); gap(); bit_in(1, 1); gap();

        // Load coinciding with a valid bit discards it
        load_pat(5);
        bit_in(1, 1); bit_in(0, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);

        // Saturation with pattern 111 and a clear on a matching bit
        load_pat(7);
        for (int k = 0; k < 6; k++) bit_in(1, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        bit_in(1, 1);

        // Reset mid-pattern, then 1 alone and a full 1,0,1
        load_pat(5);
        bit_in(1, 1); bit_in(0, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        bit_in(1, 1); gap();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);

        // Randomized traffic
        ov_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) ov_r = ~ov_r;
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 39) == 0,
                int'($urandom_range(0, 7)),
                ov_r,
                $urandom_range(0, 19) == 0);
        end

        // Drain: let the monitor consume every pushed expectation
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
